// File: rtl/adpcm_sched_pkg.sv
// adpcm_sched_pkg
//   Shared definitions for the ADPCM channel scheduler:
//   default channel count / index width and the scheduler state encoding.
package adpcm_sched_pkg;

  localparam int unsigned NCH_DEF  = 32;
  localparam int unsigned CH_W_DEF = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_FETCH = 3'd2,
    ST_START = 3'd3,
    ST_RUN   = 3'd4,
    ST_STORE = 3'd5,
    ST_DONE  = 3'd6
  } sched_state_t;

endpackage

// File: rtl/sched_wdog.sv
// sched_wdog
//   Core watchdog: counts cycles while enabled and flags expiry on the
//   TIMEOUT-th enabled cycle after a clear.
// Ports:
//   i_clk     clock
//   i_rst_n   asynchronous active-low reset
//   i_clr     synchronous clear of the count
//   i_en      count enable (core operation in flight)
//   o_expire  high during the enabled cycle that reaches TIMEOUT
module sched_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign o_expire = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adpcm_chan_sched.sv
// adpcm_chan_sched
//   Frame scheduler sharing one ADPCM core across all TDM channels. On each
//   frame sync the enabled channels are visited in ascending order: RAM
//   fetch, core start, wait for done, write strobe to the TDM output stage.
//   Optional core watchdog enabled by defining SCHED_TIMEOUT_EN.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   fs, ch_en         frame sync pulse, per-channel enable mask
//   ram_rd_en/addr    channel-RAM read strobe and address
//   core_start/ch     core start pulse, channel under processing
//   core_done         core completion pulse
//   out_wr/out_ch     TDM output write strobe and channel
//   busy              not IDLE
//   frame_done        frame completed without overrun
//   overrun           fs arrived while a frame was in progress
//   timeout_err       watchdog expired (SCHED_TIMEOUT_EN only)
module adpcm_chan_sched
  import adpcm_sched_pkg::*;
#(
  parameter int unsigned NCH     = NCH_DEF,
  parameter int unsigned CH_W    = CH_W_DEF,
  parameter int unsigned RAM_LAT = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fs,
  input  logic [NCH-1:0]  ch_en,
  output logic            ram_rd_en,
  output logic [CH_W-1:0] ram_addr,
  output logic            core_start,
  output logic [CH_W-1:0] core_ch,
  input  logic            core_done,
  output logic            out_wr,
  output logic [CH_W-1:0] out_ch,
  output logic            busy,
  output logic            frame_done,
  output logic            overrun,
  output logic            timeout_err
);

  localparam int unsigned    LAT_W   = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [CH_W:0]  PTR_END = (CH_W + 1)'(NCH);

  if (RAM_LAT < 1 || (2 ** CH_W) < NCH || TIMEOUT < 1) begin : g_param_chk
    $error("adpcm_chan_sched: illegal parameter combination");
  end

  sched_state_t    r_state, w_nxt;
  logic [CH_W:0]   r_ptr;
  logic [NCH-1:0]  r_mask, w_mask_sh;
  logic [LAT_W-1:0] r_lat;
  logic            r_restart;
  logic            w_cur_en, w_at_end, w_fetch_last, w_expire;
  logic            w_busy_st, w_ovr, w_snap;

  logic            r_ram_rd_en, r_core_start, r_out_wr, r_busy;
  logic            r_frame_done, r_overrun, r_timeout_err;
  logic [CH_W-1:0] r_ram_addr, r_core_ch, r_out_ch;

  assign w_mask_sh    = r_mask >> r_ptr;
  assign w_cur_en     = w_mask_sh[0];
  assign w_at_end     = (r_ptr == PTR_END);
  assign w_fetch_last = (r_lat == LAT_W'(RAM_LAT - 1));
  assign w_busy_st    = r_state inside {ST_SEL, ST_FETCH, ST_START, ST_RUN, ST_STORE};
  assign w_ovr        = fs && w_busy_st;

  // A pending restart is only honoured at SEL (or DONE), so an in-flight
  // core operation always drains through STORE before the new frame begins.
  assign w_snap = ((r_state == ST_IDLE) && fs) ||
                  ((r_state == ST_DONE) && (fs || r_restart)) ||
                  ((r_state == ST_SEL)  && r_restart);

`ifdef SCHED_TIMEOUT_EN
  sched_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clr   (r_state == ST_START),
    .i_en    (r_state == ST_RUN),
    .o_expire(w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (fs) w_nxt = ST_SEL;
      ST_SEL: begin
        if (r_restart)     w_nxt = ST_SEL;
        else if (w_at_end) w_nxt = ST_DONE;
        else if (w_cur_en) w_nxt = ST_FETCH;
      end
      ST_FETCH: if (w_fetch_last) w_nxt = ST_START;
      ST_START: w_nxt = ST_RUN;
      ST_RUN: begin
        // done in the expiry cycle takes precedence over the watchdog
        if (core_done)     w_nxt = ST_STORE;
        else if (w_expire) w_nxt = ST_SEL;
      end
      ST_STORE: w_nxt = ST_SEL;
      ST_DONE:  w_nxt = (fs || r_restart) ? ST_SEL : ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_mask        <= '0;
      r_lat         <= '0;
      r_restart     <= 1'b0;
      r_ram_rd_en   <= 1'b0;
      r_ram_addr    <= '0;
      r_core_start  <= 1'b0;
      r_core_ch     <= '0;
      r_out_wr      <= 1'b0;
      r_out_ch      <= '0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_overrun     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_nxt;

      if (w_snap) begin
        r_mask <= ch_en;
        r_ptr  <= '0;
      end else if (((r_state == ST_SEL) && !w_at_end && !w_cur_en) ||
                   (r_state == ST_STORE) ||
                   ((r_state == ST_RUN) && !core_done && w_expire)) begin
        r_ptr <= r_ptr + 1'b1;
      end

      r_lat <= (r_state == ST_FETCH) ? r_lat + 1'b1 : '0;

      if (w_snap)     r_restart <= 1'b0;
      else if (w_ovr) r_restart <= 1'b1;

      r_ram_rd_en <= (r_state == ST_SEL) && (w_nxt == ST_FETCH);
      if ((r_state == ST_SEL) && (w_nxt == ST_FETCH)) r_ram_addr <= r_ptr[CH_W-1:0];

      r_core_start <= (r_state == ST_FETCH) && (w_nxt == ST_START);
      if ((r_state == ST_FETCH) && (w_nxt == ST_START)) r_core_ch <= r_ptr[CH_W-1:0];

      r_out_wr <= (w_nxt == ST_STORE);
      if (w_nxt == ST_STORE) r_out_ch <= r_ptr[CH_W-1:0];

      r_busy        <= (w_nxt != ST_IDLE);
      r_frame_done  <= (w_nxt == ST_DONE);
      r_overrun     <= w_ovr;
      r_timeout_err <= (r_state == ST_RUN) && !core_done && w_expire;
    end
  end

  assign ram_rd_en   = r_ram_rd_en;
  assign ram_addr    = r_ram_addr;
  assign core_start  = r_core_start;
  assign core_ch     = r_core_ch;
  assign out_wr      = r_out_wr;
  assign out_ch      = r_out_ch;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign overrun     = r_overrun;
  assign timeout_err = r_timeout_err;

endmodule
